vend_ctrl_multi: RTL and testbench

Parametrised successor to the single-product-set vending FSM, and the main controller of the vending datapath. It supports N configurable items with per-item stock counters and four coin denominations, accepts coins through a valid-qualified strobe, and enforces a purchase timeout. It issues the vend through a valid/ready handshake to the dispenser, then pays change one coin per handshake to the coin hopper. Seven-segment decoding of `collected`/`change` stays in the separate display block.

---
 rtl/vend_ctrl_multi.sv | 147 ++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: N-item vending controller with stock, coin collection, timeout, vend and change handshakes
module vend_ctrl_multi #(
    parameter int N_ITEMS = 5,
    parameter int CENT_W = 12,
    parameter int MAX_QTY = 3,
    parameter int STOCK_W = 4,
    parameter int INIT_STOCK = 15,
    parameter int TIMEOUT_CYC = 1000,
    parameter logic [N_ITEMS*CENT_W-1:0] PRICES = {12'd150, 12'd120, 12'd100, 12'd80, 12'd50}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         item_sel,
    input  logic [1:0]         amt_sel,
    input  logic               coin_valid,
    input  logic [1:0]         coin_type,
    input  logic               cancel,
    input  logic               continue_,
    input  logic               restock,
    input  logic               vend_ready,
    input  logic               chg_ready,
    output logic [2:0]         state,
    output logic [2:0]         item,
    output logic [1:0]         amt,
    output logic [CENT_W-1:0]  collected,
    output logic [CENT_W-1:0]  change,
    output logic               insert_en,
    output logic               coin_reject,
    output logic [N_ITEMS-1:0] sold_out,
    output logic               vend_valid,
    output logic [2:0]         vend_item,
    output logic [1:0]         vend_qty,
    output logic               chg_valid,
    output logic [1:0]         chg_coin
);
    localparam logic [2:0] S_IDLE = 3'd0, S_COLLECT = 3'd1, S_VEND = 3'd2, S_CHANGE = 3'd3, S_DONE = 3'd4;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]         state_n, item_n, sel_idx, item_idx, vend_item_n;
    logic [1:0]         amt_n, amt_new, vend_qty_n, chg_coin_n;
    logic [CENT_W-1:0]  collected_n, change_n, coin_val, chg_val, change_left, total;
    logic [CENT_W:0]    sum;
    logic [TW-1:0]      tcnt, tcnt_n;
    logic               sel_ok, restock_hit, select_hit, stop, amt_hit, coin_ok, paid, chg_hs;
    logic               insert_en_n, coin_reject_n, vend_valid_n, chg_valid_n;
    logic [STOCK_W-1:0] stock [N_ITEMS];
    logic [CENT_W-1:0]  price [N_ITEMS];

    function automatic logic [CENT_W-1:0] coin_value(input logic [1:0] c);
        return c == 2'd3 ? CENT_W'(100) : c == 2'd2 ? CENT_W'(25) : c == 2'd1 ? CENT_W'(10) : CENT_W'(5);
    endfunction

    function automatic logic [1:0] greedy(input logic [CENT_W-1:0] v);
        return v >= CENT_W'(100) ? 2'd3 : v >= CENT_W'(25) ? 2'd2 : v >= CENT_W'(10) ? 2'd1 : 2'd0;
    endfunction

    for (genvar g = 0; g < N_ITEMS; g++) begin : g_item
        assign price[g] = PRICES[g*CENT_W +: CENT_W];
        assign sold_out[g] = stock[g] == '0;
    end

    assign sel_ok      = item_sel != 3'd0 && item_sel <= 3'(N_ITEMS);
    assign sel_idx     = item_sel - 3'd1;
    assign item_idx    = item - 3'd1;
    assign restock_hit = state == S_IDLE && sel_ok && restock;
    assign select_hit  = state == S_IDLE && sel_ok && !restock && stock[sel_idx] != '0;
    assign stop        = state == S_COLLECT && (cancel || tcnt == TW'(TIMEOUT_CYC - 1));
    assign amt_hit     = state == S_COLLECT && !stop && collected == '0 && amt_sel != 2'd0 &&
                         amt_sel <= 2'(MAX_QTY) && STOCK_W'(amt_sel) <= stock[item_idx];
    assign amt_new     = amt_hit ? amt_sel : amt;
    assign coin_val    = coin_value(coin_type);
    assign sum         = {1'b0, collected} + {1'b0, coin_val};
    assign coin_ok     = state == S_COLLECT && !stop && coin_valid && !sum[CENT_W];
    assign total       = price[item_idx] * CENT_W'(amt_new);
    assign paid        = coin_ok && sum[CENT_W-1:0] >= total;
    assign chg_val     = coin_value(chg_coin);
    assign change_left = change - chg_val;
    assign chg_hs      = chg_valid && chg_ready;

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_ITEMS; k++)
            if (rst || (restock_hit && sel_idx == 3'(k)))
                stock[k] <= STOCK_W'(INIT_STOCK);
            else if (vend_valid && vend_ready && item_idx == 3'(k))
                stock[k] <= stock[k] - STOCK_W'(amt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            item        <= 3'd0;
            amt         <= 2'd1;
            collected   <= '0;
            change      <= '0;
            tcnt        <= '0;
            insert_en   <= 1'b0;
            coin_reject <= 1'b0;
            vend_valid  <= 1'b0;
            vend_item   <= 3'd0;
            vend_qty    <= 2'd0;
            chg_valid   <= 1'b0;
            chg_coin    <= 2'd0;
        end else begin
            state       <= state_n;
            item        <= item_n;
            amt         <= amt_n;
            collected   <= collected_n;
            change      <= change_n;
            tcnt        <= tcnt_n;
            insert_en   <= insert_en_n;
            coin_reject <= coin_reject_n;
            vend_valid  <= vend_valid_n;
            vend_item   <= vend_item_n;
            vend_qty    <= vend_qty_n;
            chg_valid   <= chg_valid_n;
            chg_coin    <= chg_coin_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    state_n = select_hit ? S_COLLECT : S_IDLE;
            S_COLLECT: state_n = stop ? (collected != '0 ? S_CHANGE : S_IDLE) : paid ? S_VEND : S_COLLECT;
            S_VEND:    state_n = vend_ready ? (change != '0 ? S_CHANGE : S_DONE) : S_VEND;
            S_CHANGE:  state_n = chg_hs && change_left == '0 ? S_DONE : S_CHANGE;
            S_DONE:    state_n = continue_ ? S_IDLE : S_DONE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        item_n        = state_n == S_IDLE ? 3'd0 : select_hit ? item_sel : item;
        amt_n         = state_n == S_IDLE ? 2'd1 : amt_new;
        collected_n   = state_n == S_IDLE ? '0 : coin_ok ? sum[CENT_W-1:0] : collected;
        change_n      = state_n == S_IDLE ? '0 : stop ? collected : paid ? sum[CENT_W-1:0] - total :
                        chg_hs ? change_left : change;
        tcnt_n        = state == S_COLLECT && state_n == S_COLLECT && !(coin_ok || amt_hit) ? tcnt + TW'(1) : '0;
        insert_en_n   = state_n == S_COLLECT;
        coin_reject_n = coin_valid && !coin_ok;
        vend_valid_n  = state_n == S_VEND;
        vend_item_n   = vend_valid_n ? item_n : 3'd0;
        vend_qty_n    = vend_valid_n ? amt_n : 2'd0;
        chg_valid_n   = state_n == S_CHANGE;
        chg_coin_n    = chg_valid_n ? greedy(change_n) : 2'd0;
    end
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb_vend_ctrl_multi: directed plus randomized bench against a transaction-level vending model
module tb_vend_ctrl_multi;
    localparam int N = 5, CW = 12, TO = 1000;

    logic          clk = 1'b0, rst = 1'b1;
    logic [2:0]    item_sel = '0;
    logic [1:0]    amt_sel = '0, coin_type = '0;
    logic          coin_valid = 0, cancel = 0, continue_ = 0, restock = 0, vend_ready = 0, chg_ready = 0;
    logic [2:0]    state, item, vend_item;
    logic [1:0]    amt, vend_qty, chg_coin;
    logic [CW-1:0] collected, change;
    logic          insert_en, coin_reject, vend_valid, chg_valid;
    logic [N-1:0]  sold_out;

    vend_ctrl_multi dut (
        .clk(clk), .rst(rst), .item_sel(item_sel), .amt_sel(amt_sel), .coin_valid(coin_valid),
        .coin_type(coin_type), .cancel(cancel), .continue_(continue_), .restock(restock),
        .vend_ready(vend_ready), .chg_ready(chg_ready), .state(state), .item(item), .amt(amt),
        .collected(collected), .change(change), .insert_en(insert_en), .coin_reject(coin_reject),
        .sold_out(sold_out), .vend_valid(vend_valid), .vend_item(vend_item), .vend_qty(vend_qty),
        .chg_valid(chg_valid), .chg_coin(chg_coin)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int price [1:5] = '{50, 80, 100, 120, 150};
    int coin_cents [4] = '{5, 10, 25, 100};
    int m_state, m_item, m_amt, m_col, m_chg, m_tmo, m_rej;
    int m_stock [1:5];
    bit go = 0;

    function automatic int greedy(input int c);
        for (int i = 3; i >= 0; i--)
            if (c >= coin_cents[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_idle();
        m_state = 0;
        m_item = 0;
        m_amt = 1;
        m_col = 0;
        m_chg = 0;
    endtask

    // Reference model: one purchase step per clock, money kept as plain integers
    always @(posedge clk) begin : model
        int cv, lim;
        bit quit, fresh;
        if (rst) begin
            m_idle();
            m_tmo = 0;
            m_rej = 0;
            for (int k = 1; k <= N; k++) m_stock[k] = 15;
        end else begin
            cv = coin_cents[coin_type];
            m_rej = coin_valid;
            if (m_state == 0) begin
                if (item_sel >= 1 && item_sel <= N) begin
                    if (restock) m_stock[item_sel] = 15;
                    else if (m_stock[item_sel] > 0) begin
                        m_item = item_sel;
                        m_state = 1;
                        m_tmo = 0;
                    end
                end
            end else if (m_state == 1) begin
                quit = cancel || m_tmo == TO - 1;
                fresh = 0;
                if (quit) begin
                    if (m_col > 0) begin
                        m_chg = m_col;
                        m_state = 3;
                    end else m_idle();
                end else begin
                    lim = m_stock[m_item] < 3 ? m_stock[m_item] : 3;
                    if (amt_sel != 0 && m_col == 0 && amt_sel <= lim) begin
                        m_amt = amt_sel;
                        fresh = 1;
                    end
                    if (coin_valid && m_col + cv <= 4095) begin
                        m_col += cv;
                        m_rej = 0;
                        fresh = 1;
                        if (m_col >= price[m_item] * m_amt) begin
                            m_chg = m_col - price[m_item] * m_amt;
                            m_state = 2;
                        end
                    end
                    m_tmo = fresh ? 0 : m_tmo + 1;
                end
            end else if (m_state == 2) begin
                if (vend_ready) begin
                    m_stock[m_item] -= m_amt;
                    m_state = m_chg > 0 ? 3 : 4;
                end
            end else if (m_state == 3) begin
                if (chg_ready) begin
                    m_chg -= coin_cents[greedy(m_chg)];
                    if (m_chg == 0) m_state = 4;
                end
            end else if (continue_) m_idle();
        end
        go = 1;
    end

    always @(negedge clk) begin : cmp
        logic [N-1:0] so;
        if (go) begin
            for (int k = 0; k < N; k++) so[k] = m_stock[k+1] == 0;
            chk("state", state, m_state);
            chk("item", item, m_item);
            chk("amt", amt, m_amt);
            chk("collected", collected, m_col);
            chk("change", change, m_chg);
            chk("insert_en", insert_en, m_state == 1);
            chk("coin_reject", coin_reject, m_rej);
            chk("vend_valid", vend_valid, m_state == 2);
            chk("vend_item", vend_item, m_state == 2 ? m_item : 0);
            chk("vend_qty", vend_qty, m_state == 2 ? m_amt : 0);
            chk("chg_valid", chg_valid, m_state == 3);
            chk("chg_coin", chg_coin, m_state == 3 ? greedy(m_chg) : 0);
            chk("sold_out", sold_out, so);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic coin(input int t);
        coin_valid = 1;
        coin_type = 2'(t);
        step();
        coin_valid = 0;
    endtask

    task automatic sel(input int i);
        item_sel = 3'(i);
        step();
        item_sel = 0;
    endtask

    task automatic finish_to_idle();
        vend_ready = 1;
        chg_ready = 1;
        for (int i = 0; i < 20 && state != 3'd4; i++) step();
        chk("reach_done", state, 4);
        vend_ready = 0;
        chg_ready = 0;
        continue_ = 1;
        step();
        continue_ = 0;
        chk("back_idle", state, 0);
    endtask

    initial begin
        step();
        step();
        chk("rst_state", state, 0);
        chk("rst_item", item, 0);
        chk("rst_amt", amt, 1);
        chk("rst_sold_out", sold_out, 0);
        rst = 0;

        sel(1);
        chk("sel_state", state, 1);
        chk("sel_insert_en", insert_en, 1);
        coin(2);
        chk("c25_collected", collected, 25);
        coin(2);
        chk("c50_state", state, 2);
        chk("c50_vend_qty", vend_qty, 1);
        chk("c50_change", change, 0);
        vend_ready = 1;
        step();
        vend_ready = 0;
        chk("vend_done", state, 4);
        chk("m_stock1", m_stock[1], 14);
        finish_to_idle();

        sel(5);
        amt_sel = 2;
        step();
        amt_sel = 0;
        chk("amt2", amt, 2);
        repeat (3) coin(3);
        chk("i5_state", state, 2);
        chk("i5_change", change, 0);
        chk("i5_qty", vend_qty, 2);
        finish_to_idle();
        sel(2);
        coin(3);
        chk("i2_change", change, 20);
        vend_ready = 1;
        step();
        vend_ready = 0;
        chk("i2_state", state, 3);
        chk("i2_coin_a", chg_coin, 1);
        chg_ready = 1;
        step();
        chk("i2_change_b", change, 10);
        chk("i2_coin_b", chg_coin, 1);
        step();
        chg_ready = 0;
        chk("i2_done", state, 4);
        finish_to_idle();

        sel(3);
        coin(2);
        coin(1);
        cancel = 1;
        step();
        cancel = 0;
        chk("cx_state", state, 3);
        chk("cx_change", change, 35);
        chk("cx_coin", chg_coin, 2);
        chg_ready = 1;
        step();
        chk("cx_coin_b", chg_coin, 1);
        step();
        chg_ready = 0;
        chk("cx_done", state, 4);
        finish_to_idle();

        coin(3);
        chk("idle_reject", coin_reject, 1);
        chk("idle_collected", collected, 0);
        step();
        chk("reject_pulse", coin_reject, 0);
        sel(1);
        coin(1);
        coin_valid = 1;
        coin_type = 2;
        cancel = 1;
        step();
        coin_valid = 0;
        cancel = 0;
        chk("cc_reject", coin_reject, 1);
        chk("cc_collected", collected, 10);
        chk("cc_change", change, 10);
        finish_to_idle();

        repeat (5) begin
            sel(4);
            amt_sel = 3;
            step();
            amt_sel = 0;
            repeat (4) coin(3);
            finish_to_idle();
        end
        chk("so4_set", sold_out[3], 1);
        chk("m_stock4", m_stock[4], 0);
        item_sel = 4;
        step();
        step();
        chk("so4_blocked", state, 0);
        restock = 1;
        step();
        restock = 0;
        item_sel = 0;
        chk("so4_clear", sold_out[3], 0);
        chk("m_stock4_re", m_stock[4], 15);

        sel(1);
        coin(1);
        repeat (TO - 1) step();
        chk("to_hold", state, 1);
        step();
        chk("to_state", state, 3);
        chk("to_change", change, 10);
        step();
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_change", change, 0);
        chk("mid_rst_chg_valid", chg_valid, 0);
        chk("mid_rst_stock1", m_stock[1], 15);

        repeat (4000) begin
            rst        = $urandom_range(0, 499) == 0;
            item_sel   = 3'($urandom_range(0, 7));
            amt_sel    = 2'($urandom_range(0, 3));
            coin_valid = $urandom_range(0, 2) == 0;
            coin_type  = 2'($urandom_range(0, 3));
            cancel     = $urandom_range(0, 49) == 0;
            continue_  = $urandom_range(0, 3) == 0;
            restock    = $urandom_range(0, 29) == 0;
            vend_ready = $urandom_range(0, 1) == 0;
            chg_ready  = $urandom_range(0, 1) == 0;
            step();
        end
        {rst, coin_valid, cancel, continue_, restock, vend_ready, chg_ready} = '0;
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
